// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared defaults, width derivations and FSM states for the AXI-Lite W path
package axil_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BEATS_DEF = 16;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int len_w(input int data_w, input int max_beats);
    return $clog2(max_beats * (data_w / 8)) + 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/axil_strb_gen.sv
// rtl/axil_strb_gen.sv - byte-lane enable generator for one beat of a byte-addressed burst
module axil_strb_gen
  import axil_pkg::*;
#(
  parameter  int STRB_W = strb_w(DATA_W_DEF),
  parameter  int LEN_W  = len_w(DATA_W_DEF, MAX_BEATS_DEF),
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic              first,
  input  logic [OFF_W-1:0]  offset,
  input  logic [LEN_W-1:0]  rem,
  output logic [STRB_W-1:0] strb
);

  logic [LEN_W:0] lo;
  logic [LEN_W:0] hi;

  // Only the first beat starts mid-word; later beats always begin at lane 0.
  always_comb begin
    lo = first ? (LEN_W+1)'(offset) : '0;
    hi = lo + (LEN_W+1)'(rem);
    for (int i = 0; i < STRB_W; i++) begin
      strb[i] = ((LEN_W+1)'(i) >= lo) && ((LEN_W+1)'(i) < hi);
    end
  end

endmodule

// File: rtl/axil_wdata_burst.sv
// rtl/axil_wdata_burst.sv - AXI-Lite W-channel driver streaming a byte-length payload as strobed beats
module axil_wdata_burst
  import axil_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int MAX_BEATS = MAX_BEATS_DEF,
  localparam int STRB_W    = strb_w(DATA_W),
  localparam int LEN_W     = len_w(DATA_W, MAX_BEATS),
  localparam int OFF_W     = $clog2(STRB_W),
  localparam int CNT_W     = $clog2(MAX_BEATS) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [LEN_W-1:0]                 byte_count,
  input  logic [OFF_W-1:0]                 byte_offset,
  input  logic [MAX_BEATS-1:0][DATA_W-1:0] data,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [CNT_W-1:0]                 beats_sent,
  output logic [DATA_W-1:0]                wdata,
  output logic [STRB_W-1:0]                wstrb,
  output logic                             wvalid,
  input  logic                             wready
);

  localparam int             IDX_W    = $clog2(MAX_BEATS);
  localparam logic [LEN_W:0] SPAN_MAX = (LEN_W+1)'(MAX_BEATS * STRB_W);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                wvalid_q, wvalid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [LEN_W-1:0]    consumed;
  logic [LEN_W-1:0]    rem_after;
  logic [LEN_W-1:0]    gen_rem;
  logic                gen_first;
  logic [STRB_W-1:0]   gen_strb;
  logic [LEN_W:0]      span;
  logic [IDX_W-1:0]    nidx;

  always_comb begin
    consumed = '0;
    for (int i = 0; i < STRB_W; i++) begin
      consumed = consumed + LEN_W'(wstrb_q[i]);
    end
  end

  assign rem_after = rem_q - consumed;
  assign gen_first = (state_q == IDLE);
  assign gen_rem   = gen_first ? byte_count : rem_after;
  assign span      = (LEN_W+1)'(byte_offset) + (LEN_W+1)'(byte_count);
  assign nidx      = beats_q[IDX_W-1:0] + 1'b1;

  // Shared generator: beat 0 strobes while idle, following-beat strobes while sending.
  axil_strb_gen #(
    .STRB_W (STRB_W),
    .LEN_W  (LEN_W)
  ) u_strb_gen (
    .first  (gen_first),
    .offset (byte_offset),
    .rem    (gen_rem),
    .strb   (gen_strb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      beats_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wvalid_q <= wvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wvalid_d = wvalid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (byte_count == '0) begin
            done_d = 1'b1;
          end else if (span > SPAN_MAX) begin
            err_d = 1'b1;
          end else begin
            state_d  = SEND;
            rem_d    = byte_count;
            beats_d  = '0;
            wdata_d  = data[0];
            wstrb_d  = gen_strb;
            wvalid_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (wready) begin
          beats_d = beats_q + 1'b1;
          rem_d   = rem_after;
          if (rem_after == '0) begin
            state_d  = IDLE;
            wvalid_d = 1'b0;
            wstrb_d  = '0;
            done_d   = 1'b1;
          end else begin
            wdata_d = data[nidx];
            wstrb_d = gen_strb;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == SEND);
  assign done       = done_q;
  assign err        = err_q;
  assign beats_sent = beats_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wvalid     = wvalid_q;

endmodule

// File: tb/tb_axil_wdata_burst.sv
// tb/tb_axil_wdata_burst.sv - randomized self-checking bench for axil_wdata_burst
module tb_axil_wdata_burst;

  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 16;
  localparam int STRB_W    = 4;
  localparam int LEN_W     = 7;
  localparam int OFF_W     = 2;
  localparam int CNT_W     = 5;

  logic                             clk = 1'b0;
  logic                             reset;
  logic                             start;
  logic [LEN_W-1:0]                 byte_count;
  logic [OFF_W-1:0]                 byte_offset;
  logic [MAX_BEATS-1:0][DATA_W-1:0] data;
  logic                             busy, done, err, wvalid, wready;
  logic [CNT_W-1:0]                 beats_sent;
  logic [DATA_W-1:0]                wdata;
  logic [STRB_W-1:0]                wstrb;

  axil_wdata_burst #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_count(byte_count),
    .byte_offset(byte_offset), .data(data), .busy(busy), .done(done),
    .err(err), .beats_sent(beats_sent), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] obs_data[$];
  logic [STRB_W-1:0] obs_strb[$];
  int                done_cyc, err_cyc, valid_cycles, hold_bad, busy_bad, final_bad;
  logic [CNT_W-1:0]  done_beats;
  logic [STRB_W-1:0] exp_strb[MAX_BEATS];
  int                exp_n;

  // Reference: place every payload byte at absolute position off+j, beat = pos/STRB_W, lane = pos%STRB_W.
  task automatic model(input int cnt, input int off);
    for (int k = 0; k < MAX_BEATS; k++) exp_strb[k] = '0;
    for (int p = off; p < off + cnt; p++) exp_strb[p / STRB_W][p % STRB_W] = 1'b1;
    exp_n = (cnt == 0) ? 0 : (off + cnt + STRB_W - 1) / STRB_W;
  endtask

  // Caller is at a negedge. mode 0: wready=1; 1: random wready; 2: 3-cycle stall on beat 1 plus stray starts.
  task automatic do_transfer(input int cnt, input int off, input int mode);
    int                stall_cnt;
    logic              held;
    logic [DATA_W-1:0] hd;
    logic [STRB_W-1:0] hs;
    stall_cnt = 0;
    held = 1'b0;
    hd = '0;
    hs = '0;
    obs_data.delete();
    obs_strb.delete();
    done_cyc = -1; err_cyc = -1; valid_cycles = 0;
    hold_bad = 0; busy_bad = 0; final_bad = 0; done_beats = '0;
    for (int k = 0; k < MAX_BEATS; k++) data[k] = $urandom();
    byte_count  = LEN_W'(cnt);
    byte_offset = OFF_W'(off);
    start  = 1'b1;
    wready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (held && (wvalid !== 1'b1 || wdata !== hd || wstrb !== hs)) hold_bad++;
      held = 1'b0;
      if (err === 1'b1 && err_cyc < 0) err_cyc = c;
      if (done === 1'b1) begin
        done_cyc   = c;
        done_beats = beats_sent;
        if (wvalid !== 1'b0 || wstrb !== '0 || busy !== 1'b0) final_bad++;
        break;
      end
      if (err_cyc > 0) break;
      if (busy !== wvalid) busy_bad++;
      if (wvalid === 1'b1) valid_cycles++;
      case (mode)
        0: wready = 1'b1;
        1: wready = ($urandom_range(0, 3) != 0);
        default: begin
          if (obs_data.size() == 1 && stall_cnt < 3) begin
            wready = 1'b0;
            stall_cnt++;
          end else begin
            wready = 1'b1;
          end
        end
      endcase
      if (mode == 2 && obs_data.size() < 2) begin
        start = 1'b1;
        byte_count = '0;
      end
      if (wvalid === 1'b1 && wready) begin
        obs_data.push_back(wdata);
        obs_strb.push_back(wstrb);
      end else if (wvalid === 1'b1) begin
        held = 1'b1;
        hd = wdata;
        hs = wstrb;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; wready = 1'b0; byte_count = '0; byte_offset = '0;
    for (int k = 0; k < MAX_BEATS; k++) data[k] = $urandom();
    repeat (3) @(negedge clk);
    tests++;
    if ({wdata, wstrb, wvalid, busy, done, err, beats_sent} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got wdata=%h wstrb=%b wvalid=%b busy=%b done=%b err=%b beats=%0d exp all 0",
               wdata, wstrb, wvalid, busy, done, err, beats_sent);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    do_transfer(4, 0, 0);
    tests++;
    if (obs_data.size() != 1 || obs_strb[0] !== 4'b1111 || obs_data[0] !== data[0]) begin
      fails++;
      $display("FAIL single_beat got n=%0d strb=%b data=%h exp n=1 strb=1111 data=%h",
               obs_data.size(), (obs_strb.size() > 0) ? obs_strb[0] : 4'bx,
               (obs_data.size() > 0) ? obs_data[0] : 32'hx, data[0]);
    end
    tests++;
    if (done_cyc != 2 || done_beats !== 5'd1 || valid_cycles != 1 || final_bad != 0) begin
      fails++;
      $display("FAIL single_done got done_cyc=%0d beats=%0d valid=%0d final_bad=%0d exp 2 1 1 0",
               done_cyc, done_beats, valid_cycles, final_bad);
    end
  endtask

  task automatic test_strobes;
    int cnts[3] = '{6, 3, 1};
    int offs[3] = '{0, 3, 2};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      do_transfer(cnts[t], offs[t], 0);
      model(cnts[t], offs[t]);
      tests++;
      if (obs_data.size() != exp_n || done_cyc != exp_n + 1 || done_beats !== CNT_W'(exp_n) || busy_bad != 0) begin
        fails++;
        $display("FAIL strobe_shape_%0d got n=%0d done_cyc=%0d beats=%0d busy_bad=%0d exp n=%0d done_cyc=%0d",
                 t, obs_data.size(), done_cyc, done_beats, busy_bad, exp_n, exp_n + 1);
      end
      for (int k = 0; k < exp_n && k < obs_data.size(); k++) begin
        tests++;
        if (obs_strb[k] !== exp_strb[k] || obs_data[k] !== data[k]) begin
          fails++;
          $display("FAIL strobe_beat_%0d_%0d got strb=%b data=%h exp strb=%b data=%h",
                   t, k, obs_strb[k], obs_data[k], exp_strb[k], data[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    do_transfer(12, 0, 2);
    tests++;
    if (hold_bad != 0 || err_cyc != -1) begin
      fails++;
      $display("FAIL stall_hold got hold_bad=%0d err_cyc=%0d exp 0 -1", hold_bad, err_cyc);
    end
    tests++;
    if (obs_data.size() != 3 || done_cyc != 7 || done_beats !== 5'd3) begin
      fails++;
      $display("FAIL stall_done got n=%0d done_cyc=%0d beats=%0d exp 3 7 3",
               obs_data.size(), done_cyc, done_beats);
    end
    for (int k = 0; k < 3 && k < obs_data.size(); k++) begin
      tests++;
      if (obs_strb[k] !== 4'b1111 || obs_data[k] !== data[k]) begin
        fails++;
        $display("FAIL stall_beat_%0d got strb=%b data=%h exp strb=1111 data=%h",
                 k, obs_strb[k], obs_data[k], data[k]);
      end
    end
  endtask

  task automatic test_boundaries;
    @(negedge clk);
    do_transfer(0, 1, 0);
    tests++;
    if (done_cyc != 1 || valid_cycles != 0 || obs_data.size() != 0 || err_cyc != -1) begin
      fails++;
      $display("FAIL zero_len got done_cyc=%0d valid=%0d err_cyc=%0d exp 1 0 -1", done_cyc, valid_cycles, err_cyc);
    end
    @(negedge clk);
    do_transfer(61, 4 % STRB_W, 0);
    // offset field is 2 bits, so the overflow case uses offset 3 with 62 bytes instead below
    @(negedge clk);
    do_transfer(62, 3, 0);
    tests++;
    if (err_cyc != 1 || obs_data.size() != 0 || done_cyc != -1 || valid_cycles != 0) begin
      fails++;
      $display("FAIL overflow got err_cyc=%0d n=%0d done_cyc=%0d exp 1 0 -1", err_cyc, obs_data.size(), done_cyc);
    end
    @(negedge clk);
    do_transfer(64, 0, 0);
    tests++;
    if (obs_data.size() != 16 || done_cyc != 17 || done_beats !== 5'd16) begin
      fails++;
      $display("FAIL full_buffer got n=%0d done_cyc=%0d beats=%0d exp 16 17 16", obs_data.size(), done_cyc, done_beats);
    end
    for (int k = 0; k < 16 && k < obs_data.size(); k++) begin
      tests++;
      if (obs_strb[k] !== 4'b1111 || obs_data[k] !== data[k]) begin
        fails++;
        $display("FAIL full_beat_%0d got strb=%b data=%h exp strb=1111 data=%h", k, obs_strb[k], obs_data[k], data[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    do_transfer(5, 1, 0);
    do_transfer(7, 2, 0);
    model(7, 2);
    tests++;
    if (obs_data.size() != exp_n || done_cyc != exp_n + 1 || done_beats !== CNT_W'(exp_n)) begin
      fails++;
      $display("FAIL back_to_back got n=%0d done_cyc=%0d beats=%0d exp n=%0d done_cyc=%0d",
               obs_data.size(), done_cyc, done_beats, exp_n, exp_n + 1);
    end
    for (int k = 0; k < exp_n && k < obs_strb.size(); k++) begin
      tests++;
      if (obs_strb[k] !== exp_strb[k]) begin
        fails++;
        $display("FAIL b2b_strb_%0d got %b exp %b", k, obs_strb[k], exp_strb[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int spurious;
    n = 0;
    spurious = 0;
    @(negedge clk);
    for (int k = 0; k < MAX_BEATS; k++) data[k] = $urandom();
    byte_count = 7'd20; byte_offset = '0; start = 1'b1; wready = 1'b1;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (wvalid === 1'b1) n++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (n != 2 || {wdata, wstrb, wvalid, busy, done, err, beats_sent} !== '0) begin
      fails++;
      $display("FAIL reset_mid got n=%0d wvalid=%b wstrb=%b busy=%b done=%b beats=%0d exp n=2 all 0",
               n, wvalid, wstrb, busy, done, beats_sent);
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || wvalid !== 1'b0) spurious++;
    end
    tests++;
    if (spurious != 0) begin
      fails++;
      $display("FAIL reset_no_done got spurious=%0d exp 0", spurious);
    end
    do_transfer(8, 0, 0);
    tests++;
    if (obs_data.size() != 2 || done_cyc != 3 || done_beats !== 5'd2) begin
      fails++;
      $display("FAIL after_reset got n=%0d done_cyc=%0d beats=%0d exp 2 3 2", obs_data.size(), done_cyc, done_beats);
    end
  endtask

  task automatic test_random;
    int cnt, off;
    for (int it = 0; it < 30; it++) begin
      off = $urandom_range(0, 3);
      cnt = $urandom_range(0, 64);
      @(negedge clk);
      do_transfer(cnt, off, 1);
      if (cnt == 0) begin
        tests++;
        if (done_cyc != 1 || obs_data.size() != 0) begin
          fails++;
          $display("FAIL rand_zero_%0d got done_cyc=%0d n=%0d exp 1 0", it, done_cyc, obs_data.size());
        end
      end else if (off + cnt > MAX_BEATS * STRB_W) begin
        tests++;
        if (err_cyc != 1 || obs_data.size() != 0) begin
          fails++;
          $display("FAIL rand_err_%0d got err_cyc=%0d n=%0d exp 1 0", it, err_cyc, obs_data.size());
        end
      end else begin
        model(cnt, off);
        tests++;
        if (obs_data.size() != exp_n || done_cyc < exp_n + 1 || done_beats !== CNT_W'(exp_n) ||
            hold_bad != 0 || busy_bad != 0 || final_bad != 0) begin
          fails++;
          $display("FAIL rand_xfer_%0d cnt=%0d off=%0d got n=%0d done_cyc=%0d beats=%0d hold_bad=%0d busy_bad=%0d exp n=%0d",
                   it, cnt, off, obs_data.size(), done_cyc, done_beats, hold_bad, busy_bad, exp_n);
        end
        for (int k = 0; k < exp_n && k < obs_data.size(); k++) begin
          tests++;
          if (obs_strb[k] !== exp_strb[k] || obs_data[k] !== data[k]) begin
            fails++;
            $display("FAIL rand_beat_%0d_%0d got strb=%b data=%h exp strb=%b data=%h",
                     it, k, obs_strb[k], obs_data[k], exp_strb[k], data[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_strobes();
    test_backpressure();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
